// File: rtl/cruise_ctrl_p_if.sv
// Driver/actuator/dashboard bundle for cruise_ctrl_p; slave is the controller's view.
interface cruise_ctrl_p_if #(
    parameter int SPEED_W = 8,
    parameter int AWARE_W = 3,
    parameter int FUEL_W  = 3
);
    logic               speed_up;
    logic               speed_down;
    logic [AWARE_W-1:0] awareness;
    logic [SPEED_W-1:0] speed;
    logic [SPEED_W-1:0] c_speed;
    logic [FUEL_W-1:0]  fuel;
    logic               brake;
    logic               L;
    logic               G;
    logic               EQ;
    logic [1:0]         state;

    modport master (
        output speed_up, speed_down, awareness,
        input  speed, c_speed, fuel, brake, L, G, EQ, state
    );

    modport slave (
        input  speed_up, speed_down, awareness,
        output speed, c_speed, fuel, brake, L, G, EQ, state
    );
endinterface

// File: rtl/cruise_ctrl_p.sv
// Cruise controller: edge-detected set speed, current speed ramped toward a hazard-capped target.
// Outputs registered (flags combinational); CRUISE_RESUME_EN keeps the set speed through BRAKE.
module cruise_ctrl_p #(
    parameter int SPEED_W   = 8,
    parameter int SET_STEP  = 8,
    parameter int STEP      = 1,
    parameter int MAX_SPEED = 200,
    parameter int AWARE_W   = 3,
    parameter int BRAKE_LVL = 5,
    parameter int FUEL_W    = 3,
    parameter int FUEL_HOLD = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    cruise_ctrl_p_if.slave bus
);
    localparam logic [1:0] HOLD  = 2'd0;
    localparam logic [1:0] ACCEL = 2'd1;
    localparam logic [1:0] DECEL = 2'd2;
    localparam logic [1:0] BRAKE = 2'd3;

    localparam int SW1 = SPEED_W + 1;
    localparam logic [SPEED_W-1:0] MAX_V   = SPEED_W'(MAX_SPEED);
    localparam logic [SW1-1:0]     MAX_X   = SW1'(MAX_SPEED);
    localparam logic [SW1-1:0]     SET_X   = SW1'(SET_STEP);
    localparam logic [SW1-1:0]     STEP_X  = SW1'(STEP);
    localparam logic [SW1-1:0]     STEP2_X = SW1'(2 * STEP);
    localparam logic [AWARE_W-1:0] BRAKE_V = AWARE_W'(BRAKE_LVL);

    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SPEED_W-1:0] c_speed_q, c_speed_d;
    logic [FUEL_W-1:0]  fuel_q, fuel_d;
    logic               brake_q, brake_d;
    logic [1:0]         state_q, state_d;
    logic               up_prev_q, up_prev_d;
    logic               dn_prev_q, dn_prev_d;

    logic [SPEED_W-1:0] cap, tgt;
    logic [SW1-1:0]     spd_x, cs_x, tgt_x, up_sum, acc_sum;
    logic               up_press, dn_press;

    always_comb begin
        cap      = MAX_V >> bus.awareness;
        tgt      = (speed_q < cap) ? speed_q : cap;
        spd_x    = {1'b0, speed_q};
        cs_x     = {1'b0, c_speed_q};
        tgt_x    = {1'b0, tgt};
        up_sum   = spd_x + SET_X;
        acc_sum  = cs_x + STEP_X;
        up_press = bus.speed_up & ~up_prev_q;
        dn_press = bus.speed_down & ~dn_prev_q;
    end

    always_comb begin
        up_prev_d = bus.speed_up;
        dn_prev_d = bus.speed_down;
        speed_d   = speed_q;
        c_speed_d = c_speed_q;
        fuel_d    = '0;
        brake_d   = 1'b0;

        if (bus.awareness >= BRAKE_V)
            state_d = BRAKE;
        else if (c_speed_q < tgt)
            state_d = ACCEL;
        else if (c_speed_q > tgt)
            state_d = DECEL;
        else
            state_d = HOLD;

        case (state_d)
            ACCEL: begin
                c_speed_d = (acc_sum > tgt_x) ? tgt : acc_sum[SPEED_W-1:0];
                fuel_d    = '1;
            end
            DECEL: begin
                c_speed_d = (cs_x < tgt_x + STEP_X) ? tgt : c_speed_q - STEP_X[SPEED_W-1:0];
            end
            BRAKE: begin
                c_speed_d = (cs_x < STEP2_X) ? '0 : c_speed_q - STEP2_X[SPEED_W-1:0];
                brake_d   = 1'b1;
            end
            default: begin
                fuel_d = FUEL_W'(FUEL_HOLD);
            end
        endcase

        // Presses are dropped while braking and on the exit edge; history still tracks.
        if (state_d == BRAKE) begin
`ifndef CRUISE_RESUME_EN
            speed_d = '0;
`endif
        end else if (state_q != BRAKE && (up_press ^ dn_press)) begin
            if (up_press)
                speed_d = (up_sum > MAX_X) ? MAX_V : up_sum[SPEED_W-1:0];
            else
                speed_d = (spd_x < SET_X) ? '0 : speed_q - SET_X[SPEED_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            speed_q   <= '0;
            c_speed_q <= '0;
            fuel_q    <= '0;
            brake_q   <= 1'b0;
            state_q   <= HOLD;
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
        end else begin
            speed_q   <= speed_d;
            c_speed_q <= c_speed_d;
            fuel_q    <= fuel_d;
            brake_q   <= brake_d;
            state_q   <= state_d;
            up_prev_q <= up_prev_d;
            dn_prev_q <= dn_prev_d;
        end
    end

    assign bus.speed   = speed_q;
    assign bus.c_speed = c_speed_q;
    assign bus.fuel    = fuel_q;
    assign bus.brake   = brake_q;
    assign bus.state   = state_q;
    assign bus.L       = (c_speed_q < tgt);
    assign bus.G       = (c_speed_q > tgt);
    assign bus.EQ      = (c_speed_q == tgt);
endmodule

// File: tb/tb_cruise_ctrl_p.sv
// Directed bench for cruise_ctrl_p with hand-computed expectations.
module tb_cruise_ctrl_p;
    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    cruise_ctrl_p_if #(.SPEED_W(8), .AWARE_W(3), .FUEL_W(3)) bus ();

    cruise_ctrl_p dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.speed_up   = 1'b0;
        bus.speed_down = 1'b0;
        bus.awareness  = '0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic press_up();
        bus.speed_up = 1'b1;
        tick();
        bus.speed_up = 1'b0;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_speed"}, 32'(bus.speed), 0);
        chk({tag, "_cspeed"}, 32'(bus.c_speed), 0);
        chk({tag, "_state"}, 32'(bus.state), 0);
        chk({tag, "_fuel"}, 32'(bus.fuel), 0);
        chk({tag, "_brake"}, 32'(bus.brake), 0);
        chk({tag, "_L"}, 32'(bus.L), 0);
        chk({tag, "_G"}, 32'(bus.G), 0);
        chk({tag, "_EQ"}, 32'(bus.EQ), 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b1;
        #1;
        do_reset();
        #1;
        chk_reset_vals("rst");

        // Set and ramp: two presses -> 16, ramp 1 per edge.
        bus.speed_up = 1'b1; tick();
        chk("p1_speed", 32'(bus.speed), 8);
        chk("p1_state", 32'(bus.state), 0);
        bus.speed_up = 1'b0; tick();
        chk("ramp_start_cs", 32'(bus.c_speed), 1);
        bus.speed_up = 1'b1; tick();
        chk("p2_speed", 32'(bus.speed), 16);
        chk("ramp_cs2", 32'(bus.c_speed), 2);
        chk("ramp_state", 32'(bus.state), 1);
        chk("ramp_fuel", 32'(bus.fuel), 7);
        chk("ramp_L", 32'(bus.L), 1);
        bus.speed_up = 1'b0;
        repeat (14) tick();
        chk("ramp_end_cs", 32'(bus.c_speed), 16);
        chk("ramp_end_state", 32'(bus.state), 1);
        tick();
        chk("hold_state", 32'(bus.state), 0);
        chk("hold_fuel", 32'(bus.fuel), 2);
        chk("hold_EQ", 32'(bus.EQ), 1);

        // Awareness cap.
        bus.awareness = 3'd3; tick();
        chk("aw3_state", 32'(bus.state), 0);
        chk("aw3_cs", 32'(bus.c_speed), 16);
        bus.awareness = 3'd4; #1;
        chk("aw4_G_live", 32'(bus.G), 1);
        chk("aw4_L_live", 32'(bus.L), 0);
        tick();
        chk("aw4_state", 32'(bus.state), 2);
        chk("aw4_cs", 32'(bus.c_speed), 15);
        chk("aw4_fuel", 32'(bus.fuel), 0);
        repeat (3) tick();
        chk("aw4_cs_end", 32'(bus.c_speed), 12);
        chk("aw4_state_end", 32'(bus.state), 2);
        tick();
        chk("aw4_hold", 32'(bus.state), 0);
        chk("aw4_EQ", 32'(bus.EQ), 1);
        bus.awareness = 3'd0; #1;
        chk("aw0_L_live", 32'(bus.L), 1);
        tick();
        chk("aw0_state", 32'(bus.state), 1);
        chk("aw0_cs", 32'(bus.c_speed), 13);
        repeat (3) tick();
        chk("aw0_cs_end", 32'(bus.c_speed), 16);
        tick();
        chk("aw0_hold", 32'(bus.state), 0);

        // Brake.
        bus.awareness = 3'd5; tick();
        chk("brk_brake", 32'(bus.brake), 1);
        chk("brk_state", 32'(bus.state), 3);
        chk("brk_cs", 32'(bus.c_speed), 14);
        chk("brk_fuel", 32'(bus.fuel), 0);
`ifdef CRUISE_RESUME_EN
        chk("brk_speed", 32'(bus.speed), 16);
`else
        chk("brk_speed", 32'(bus.speed), 0);
`endif
        bus.speed_up = 1'b1; tick();
        chk("brk_cs12", 32'(bus.c_speed), 12);
`ifdef CRUISE_RESUME_EN
        chk("brk_press_ign", 32'(bus.speed), 16);
`else
        chk("brk_press_ign", 32'(bus.speed), 0);
`endif
        bus.speed_up = 1'b0; tick();
        chk("brk_cs10", 32'(bus.c_speed), 10);
        repeat (5) tick();
        chk("brk_cs0", 32'(bus.c_speed), 0);
        tick();
        chk("brk_cs_floor", 32'(bus.c_speed), 0);
        chk("brk_still", 32'(bus.brake), 1);

        // Resume.
        bus.awareness = 3'd0; tick();
        chk("res_brake", 32'(bus.brake), 0);
`ifdef CRUISE_RESUME_EN
        chk("res_speed", 32'(bus.speed), 16);
        chk("res_state", 32'(bus.state), 1);
        chk("res_cs", 32'(bus.c_speed), 1);
        repeat (15) tick();
        chk("res_cs_end", 32'(bus.c_speed), 16);
        tick();
        chk("res_hold", 32'(bus.state), 0);
`else
        chk("res_speed", 32'(bus.speed), 0);
        chk("res_state", 32'(bus.state), 0);
        chk("res_cs", 32'(bus.c_speed), 0);
        tick();
        chk("res_cs_stay", 32'(bus.c_speed), 0);
`endif

        // Edge detection and saturation.
        do_reset();
        bus.speed_up = 1'b1;
        repeat (10) tick();
        chk("held_speed", 32'(bus.speed), 8);
        bus.speed_up = 1'b0; tick();
        repeat (24) press_up();
        chk("sat_200", 32'(bus.speed), 200);
        press_up();
        chk("sat_hold", 32'(bus.speed), 200);
        bus.speed_up = 1'b1; bus.speed_down = 1'b1; tick();
        chk("both_press", 32'(bus.speed), 200);
        bus.speed_up = 1'b0; bus.speed_down = 1'b0; tick();
        bus.speed_down = 1'b1; tick();
        chk("down_192", 32'(bus.speed), 192);
        bus.speed_down = 1'b0; tick();
        do_reset();
        bus.speed_down = 1'b1; tick();
        chk("down_at0", 32'(bus.speed), 0);
        bus.speed_down = 1'b0; tick();

        // Async reset mid-ramp.
        press_up();
        tick();
        chk("mid_cs", 32'(bus.c_speed), 2);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        #2;
        reset_n = 1'b1;
        bus.speed_up = 1'b1; tick();
        chk("post_rst_speed", 32'(bus.speed), 8);
        chk("post_rst_cs", 32'(bus.c_speed), 0);
        bus.speed_up = 1'b0; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cruise_ctrl_p.md
# cruise_ctrl_p

Parametrised second-generation cruise controller. It holds a driver set speed, adjusted by edge-detected `speed_up`/`speed_down` presses. It ramps the current vehicle speed toward an effective target, which is the set speed capped by the `awareness` hazard level. Hazard levels at or above a threshold force a braking state. The block sits between the driver-input conditioning and the throttle/brake actuator drivers, and exports speed/compare flags for the dashboard.

## Interface
- `SPEED_W`, 8, width of all speed values
- `SET_STEP`, 8, set-speed change per button press
- `STEP`, 1, current-speed change per cycle in ACCEL/DECEL; braking uses 2*STEP
- `MAX_SPEED`, 200, set-speed ceiling, must be < 2^SPEED_W
- `AWARE_W`, 3, width of `awareness`
- `BRAKE_LVL`, 5, awareness level that forces BRAKE
- `FUEL_W`, 3, width of `fuel`
- `FUEL_HOLD`, 2, fuel command in HOLD
- `clock`  in  1  rising-edge clock; single clock domain
- `reset_n`  in  1  asynchronous, active-low reset
- `speed_up`  in  1  increase set speed, level input, edge-detected internally
- `speed_down`  in  1  decrease set speed, level input, edge-detected internally
- `awareness`  in  AWARE_W  hazard level; 0 means clear road
- `speed`  out  SPEED_W  registered set speed
- `c_speed`  out  SPEED_W  registered current speed
- `fuel`  out  FUEL_W  registered throttle command
- `brake`  out  1  registered brake command
- `L`, `G`, `EQ`  out  1 each  combinational compare: `c_speed` <, >, == effective target
- `state`  out  2  FSM state code: HOLD=0, ACCEL=1, DECEL=2, BRAKE=3

## Operation
- **Press detection.** One-cycle history registers hold the previous `speed_up` and `speed_down` samples. A press is a sample of 1 whose previous sample was 0.
  - up press: `speed` = min(`speed`+SET_STEP, MAX_SPEED)
  - down press: `speed` = max(`speed`−SET_STEP, 0)
  - up and down presses in the same cycle: no change
  - presses are ignored while the FSM is in BRAKE
- **Arithmetic.** All speed arithmetic uses SPEED_W+1 bits internally, then saturates. `speed` and `c_speed` never wrap.
- **Cap and effective target.**
  - cap = MAX_SPEED >> `awareness` when `awareness` < BRAKE_LVL
  - tgt = min(`speed`, cap)
  - tgt is combinational from the current `speed` register and the live `awareness` input
- **Next-state selection**, in priority order:
  1. `awareness` ≥ BRAKE_LVL → BRAKE
  2. `c_speed` < tgt → ACCEL
  3. `c_speed` > tgt → DECEL
  4. otherwise → HOLD
- **Per-state action.** On each edge `c_speed` is updated by the state being entered:
  - ACCEL: min(`c_speed`+STEP, tgt); `fuel` = 2^FUEL_W−1; `brake` = 0
  - DECEL: max(`c_speed`−STEP, tgt); `fuel` = 0; `brake` = 0
  - HOLD: `c_speed` unchanged; `fuel` = FUEL_HOLD; `brake` = 0
  - BRAKE: max(`c_speed`−2*STEP, 0); `fuel` = 0; `brake` = 1. On entry, `speed` is cleared to 0 (see Configuration).
- **Leaving BRAKE.** Exit occurs on the first edge that samples `awareness` < BRAKE_LVL, going to ACCEL, DECEL or HOLD by the normal rules. The previous-sample press registers keep updating during BRAKE, so a button held through braking does not register a press on exit.

## Timing
- **Reset** (asynchronous, immediate): `speed`=0, `c_speed`=0, `state`=HOLD, `fuel`=0, `brake`=0, press-history registers=0. Flags then read `L`=0, `G`=0, `EQ`=1.
- **Press latency.** A press sampled at edge n updates `speed` at edge n. `c_speed` begins moving at edge n+1.
- **Ramp duration.** Ramp from `c_speed`=a to tgt=b takes ceil(|b−a|/STEP) edges. The final step lands exactly on b, and the next edge enters HOLD.
- **Compare flags** follow the live `awareness` input with no register delay.
- **Awareness to brake latency:** `awareness` ≥ BRAKE_LVL sampled at edge n gives `brake`=1 and `state`=BRAKE after edge n.
- **Reset mid-ramp:** all outputs return to their reset values asynchronously. Operation restarts on the first edge after `reset_n` deasserts.

## Configuration
- `CRUISE_RESUME_EN`
  - **Defined:** BRAKE entry retains `speed`. After exit, the FSM ramps back toward min(`speed`, cap), which resumes the previous cruise speed.
  - **Undefined:** BRAKE entry clears `speed` to 0. After exit, `c_speed` decelerates to 0 and the driver must re-press to set a speed.

## Test plan
- **Set and ramp.** Reset, then two single-cycle `speed_up` pulses with `awareness`=0 → `speed`=16. `c_speed` ramps 1/cycle with `fuel`=7, `L`=1, reaches 16, then `state`=HOLD, `fuel`=2, `EQ`=1.
- **Edge detection and saturation.**
  - `speed_up` held 10 cycles → `speed`=8 only.
  - 26 separate presses → `speed`=200, never 208.
  - `speed_down` press at 0 → stays 0.
  - simultaneous up+down press → no change.
- **Awareness cap.** `speed`=`c_speed`=16:
  - `awareness`=3 (cap 25) → HOLD.
  - `awareness`=4 (cap 12) → DECEL with `G`=1 and `fuel`=0, `c_speed` reaches 12 after 4 edges, then HOLD.
  - `awareness` back to 0 → ACCEL back to 16.
- **Brake.** `c_speed`=16, `awareness`=5:
  - after the next edge: `brake`=1, `state`=3, `c_speed` 14, 12, …, 0.
  - presses during BRAKE are ignored.
- **Resume.** After braking, set `awareness`=0:
  - without `CRUISE_RESUME_EN`: `speed`=0, `c_speed` stays 0 in HOLD.
  - with it: `speed`=16 retained, `c_speed` ramps back to 16.
- **Async reset.** Assert `reset_n`=0 mid-ramp between clock edges → all outputs reach reset values before the next edge. Deassert, then one press → `speed`=8.
